// File: rtl/piso_tx.sv
`default_nettype none
// ============================================================================
//  Module      : piso_tx
//  Description : Parallel-in serial-out transmitter. Accepts a WIDTH-bit word
//                over a valid/ready handshake and shifts it out LSB first,
//                one bit per clock, with s_valid/s_last framing strobes.
//                Optional feature macro: PISO_TX_DBUF_EN adds a one-word
//                hold buffer so back-to-back frames stream with no gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_tx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] p_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             s_out,
  output logic             s_valid,
  output logic             s_last,
  output logic             busy
);

  localparam int              C_CW       = $clog2(WIDTH);
  localparam logic [C_CW-1:0] C_LAST_CNT = C_CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] w_sr_nxt;
  logic [C_CW-1:0]  r_cnt;
  logic [C_CW-1:0]  w_cnt_nxt;
  logic             w_accept;
  logic             w_last_bit;
  logic             w_hold_full;

`ifdef PISO_TX_DBUF_EN
  logic [WIDTH-1:0] r_hold;
  logic [WIDTH-1:0] w_hold_nxt;
  logic             r_hold_full;
  logic             w_hold_full_nxt;

  // Ready only depends on the hold flag: a word can always be parked
  // somewhere (sr when idle or at the last bit, hold otherwise).
  assign w_hold_full = r_hold_full;
  assign load_ready  = !r_hold_full;
`else
  assign w_hold_full = 1'b0;
  assign load_ready  = (r_state == S_IDLE);
`endif

  assign w_accept   = load_valid && load_ready;
  assign w_last_bit = (r_state == S_SHIFT) && (r_cnt == C_LAST_CNT);

  // Serial and framing outputs; sr is cleared in IDLE so s_out idles low.
  assign s_out   = r_sr[0];
  assign s_valid = (r_state == S_SHIFT);
  assign s_last  = w_last_bit;
  assign busy    = s_valid || w_hold_full;

  // Next-state, shift-register, counter and hold-buffer updates.
  always_comb begin
    w_state_nxt = r_state;
    w_sr_nxt    = r_sr;
    w_cnt_nxt   = r_cnt;
`ifdef PISO_TX_DBUF_EN
    w_hold_nxt      = r_hold;
    w_hold_full_nxt = r_hold_full;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_SHIFT;
          w_sr_nxt    = p_in;
          w_cnt_nxt   = '0;
        end
      end
      S_SHIFT: begin
        if (!w_last_bit) begin
          w_sr_nxt  = {1'b0, r_sr[WIDTH-1:1]};
          w_cnt_nxt = r_cnt + 1'b1;
`ifdef PISO_TX_DBUF_EN
          // Mid-frame accept parks the word until the last bit edge.
          if (w_accept) begin
            w_hold_nxt      = p_in;
            w_hold_full_nxt = 1'b1;
          end
`endif
        end else begin
`ifdef PISO_TX_DBUF_EN
          if (r_hold_full) begin
            // Held word takes priority; load_ready is low so no accept now.
            w_sr_nxt        = r_hold;
            w_cnt_nxt       = '0;
            w_hold_full_nxt = 1'b0;
          end else if (w_accept) begin
            w_sr_nxt  = p_in;
            w_cnt_nxt = '0;
          end else begin
            w_sr_nxt    = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
          end
`else
          w_sr_nxt    = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
`endif
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_sr_nxt    = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State register; reset wins over any simultaneous accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sr    <= w_sr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

`ifdef PISO_TX_DBUF_EN
  // Hold buffer register; reset discards any parked word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else begin
      r_hold      <= w_hold_nxt;
      r_hold_full <= w_hold_full_nxt;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_piso_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_piso_tx
//  Description : Self-checking bench for piso_tx (WIDTH=4). Expected serial
//                bits are queued when words are offered and compared as the
//                DUT emits them. Honours PISO_TX_DBUF_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_tx;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] p_in;
  logic         load_valid;
  logic         load_ready;
  logic         s_out;
  logic         s_valid;
  logic         s_last;
  logic         busy;

  int n_checks;
  int n_errors;

  // Each entry: {expected s_out, expected s_last}
  logic [1:0] exp_q[$];
  logic [1:0] m_e;

  piso_tx #(.WIDTH(W)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .p_in       (p_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .s_out      (s_out),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) begin
      exp_q.push_back({w[i], (i == W - 1) ? 1'b1 : 1'b0});
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Output monitor: every s_valid cycle must match the next queued bit.
  always @(posedge clk) begin
    #1;
    if (s_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_bit", 32'd1, 32'd0);
      end else begin
        m_e = exp_q.pop_front();
        chk("s_out", {31'd0, s_out}, {31'd0, m_e[1]});
        chk("s_last", {31'd0, s_last}, {31'd0, m_e[0]});
      end
    end else begin
      chk("idle_s_out", {31'd0, s_out}, 32'd0);
      chk("idle_s_last", {31'd0, s_last}, 32'd0);
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst        = 1'b1;
    load_valid = 1'b1;
    p_in       = 4'hF;

    // ---- Reset with load_valid high: nothing may start ----
    repeat (2) cyc();
    rst        = 1'b0;
    load_valid = 1'b0;
    chk("rst_ready", {31'd0, load_ready}, 32'd1);
    chk("rst_s_out", {31'd0, s_out}, 32'd0);
    chk("rst_s_valid", {31'd0, s_valid}, 32'd0);
    chk("rst_s_last", {31'd0, s_last}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    cyc();

    // ---- Single frame 4'b1011 ----
    chk("sf_ready_idle", {31'd0, load_ready}, 32'd1);
    load_valid = 1'b1;
    p_in       = 4'b1011;
    push_word(4'b1011);
    for (int k = 1; k <= W; k++) begin
      cyc();
      load_valid = 1'b0;
      p_in       = 4'h0;
      chk("sf_s_valid", {31'd0, s_valid}, 32'd1);
      chk("sf_busy", {31'd0, busy}, 32'd1);
`ifdef PISO_TX_DBUF_EN
      chk("sf_ready", {31'd0, load_ready}, 32'd1);
`else
      chk("sf_ready", {31'd0, load_ready}, 32'd0);
`endif
    end
    cyc();
    chk("sf_end_s_valid", {31'd0, s_valid}, 32'd0);
    chk("sf_end_busy", {31'd0, busy}, 32'd0);
    chk("sf_end_ready", {31'd0, load_ready}, 32'd1);
    cyc();

`ifdef PISO_TX_DBUF_EN
    // ---- Streaming A, 5, F through the hold buffer ----
    load_valid = 1'b1;
    p_in       = 4'hA;
    push_word(4'hA);
    for (int k = 1; k <= 3 * W; k++) begin
      cyc();
      if (k == 1) begin
        p_in = 4'h5;
        push_word(4'h5);
      end else if (k == 2) begin
        p_in = 4'hF;
        push_word(4'hF);
      end else if (k == 6) begin
        load_valid = 1'b0;
        p_in       = 4'h0;
      end
      chk("db_s_valid", {31'd0, s_valid}, 32'd1);
      chk("db_busy", {31'd0, busy}, 32'd1);
      chk("db_ready", {31'd0, load_ready},
          ((k >= 2 && k <= 4) || (k >= 6 && k <= 8)) ? 32'd0 : 32'd1);
    end
    cyc();
    chk("db_end_s_valid", {31'd0, s_valid}, 32'd0);
    cyc();
`else
    // ---- Back-to-back A then 5 without the buffer ----
    load_valid = 1'b1;
    p_in       = 4'hA;
    push_word(4'hA);
    for (int k = 1; k <= W; k++) begin
      cyc();
      p_in = 4'h5;
      chk("bb_s_valid", {31'd0, s_valid}, 32'd1);
      chk("bb_ready_shift", {31'd0, load_ready}, 32'd0);
    end
    cyc();
    chk("bb_gap_s_valid", {31'd0, s_valid}, 32'd0);
    chk("bb_gap_ready", {31'd0, load_ready}, 32'd1);
    push_word(4'h5);
    for (int k = 1; k <= W; k++) begin
      cyc();
      load_valid = 1'b0;
      chk("bb2_s_valid", {31'd0, s_valid}, 32'd1);
      chk("bb2_ready_shift", {31'd0, load_ready}, 32'd0);
    end
    cyc();
    chk("bb_end_s_valid", {31'd0, s_valid}, 32'd0);
    cyc();
`endif

    // ---- Reset mid-frame ----
    load_valid = 1'b1;
    p_in       = 4'hF;
    push_word(4'hF);
    cyc();
`ifdef PISO_TX_DBUF_EN
    p_in = 4'h3;
`else
    load_valid = 1'b0;
`endif
    cyc();
    chk("rmf_busy_before", {31'd0, busy}, 32'd1);
    load_valid = 1'b0;
    rst        = 1'b1;
    exp_q.delete();
    cyc();
    rst = 1'b0;
    chk("rmf_s_valid", {31'd0, s_valid}, 32'd0);
    chk("rmf_busy", {31'd0, busy}, 32'd0);
    chk("rmf_ready", {31'd0, load_ready}, 32'd1);
    chk("rmf_s_out", {31'd0, s_out}, 32'd0);
    repeat (8) cyc();

    // ---- Reset overrides a simultaneous accept ----
    rst        = 1'b1;
    load_valid = 1'b1;
    p_in       = 4'h9;
    cyc();
    rst        = 1'b0;
    load_valid = 1'b0;
    chk("rprio_s_valid", {31'd0, s_valid}, 32'd0);
    repeat (6) cyc();

    // ---- Backpressure: single-cycle pulse during SHIFT ----
    load_valid = 1'b1;
    p_in       = 4'h6;
    push_word(4'h6);
    cyc();
    load_valid = 1'b0;
    cyc();
`ifdef PISO_TX_DBUF_EN
    chk("bp_ready", {31'd0, load_ready}, 32'd1);
    push_word(4'h9);
`else
    chk("bp_ready", {31'd0, load_ready}, 32'd0);
`endif
    load_valid = 1'b1;
    p_in       = 4'h9;
    cyc();
    load_valid = 1'b0;
    p_in       = 4'h0;
    repeat (12) cyc();
    chk("bp_end_s_valid", {31'd0, s_valid}, 32'd0);
    chk("bp_end_busy", {31'd0, busy}, 32'd0);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
